// File: rtl/vm_pkg.sv
// Shared types and coin constants for the multi-product vending machine.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } vm_state_e;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_N,
    COIN_D,
    COIN_Q
  } coin_sel_e;

  localparam int unsigned NICKEL  = 5;
  localparam int unsigned DIME    = 10;
  localparam int unsigned QUARTER = 25;

  function automatic logic [4:0] coin_value(input coin_sel_e c);
    case (c)
      COIN_N:  coin_value = 5'(NICKEL);
      COIN_D:  coin_value = 5'(DIME);
      COIN_Q:  coin_value = 5'(QUARTER);
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Serial change return: loads an amount, then pays it out one dime or nickel per cycle.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned CREDIT_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic                run,
  output logic                change_d,
  output logic                change_n,
  output logic [CREDIT_W-1:0] remainder,
  output logic                done
);

  logic [CREDIT_W-1:0] src;
  logic [CREDIT_W-1:0] src_next;
  logic                take_dime;
  logic                fire;

  // The first coin is paid on the load edge itself, so remainder always
  // shows the amount still owed after the pulse currently on the outputs.
  always_comb begin
    fire      = load || (run && (remainder != '0));
    src       = load ? load_val : remainder;
    take_dime = (src >= CREDIT_W'(DIME));
    if (take_dime) begin
      src_next = src - CREDIT_W'(DIME);
    end else if (src >= CREDIT_W'(NICKEL)) begin
      src_next = src - CREDIT_W'(NICKEL);
    end else begin
      src_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remainder <= '0;
      change_d  <= 1'b0;
      change_n  <= 1'b0;
    end else begin
      change_d <= fire && take_dime;
      change_n <= fire && !take_dime;
      if (fire) begin
        remainder <= src_next;
      end
    end
  end

  assign done = run && !load && (remainder == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product coin vending controller with per-item stock and serial change return.
// Optional idle refund timeout enabled by defining REFUND_TIMEOUT_EN.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int unsigned PRICE       = 15,
  parameter int unsigned CREDIT_MAX  = 95,
  parameter int unsigned CREDIT_W    = 7,
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned STOCK_INIT  = 3,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned TIMEOUT_CYC = 1000,
  localparam int unsigned SEL_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 N,
  input  logic                 D,
  input  logic                 Q,
  input  logic                 buy,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 cancel,
  output logic                 vend,
  output logic [SEL_W-1:0]     vend_item,
  output logic                 change_d,
  output logic                 change_n,
  output logic                 coin_reject,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  if (((PRICE % 5) != 0) || (PRICE > CREDIT_MAX) || ((CREDIT_MAX % 5) != 0) ||
      (TIMEOUT_CYC == 0) || (NUM_ITEMS == 0) || (NUM_ITEMS > 16)) begin : g_param_check
    $error("vending_machine_multi: illegal parameter set");
  end

  vm_state_e            state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic                 vend_d;
  logic [SEL_W-1:0]     vend_item_d;
  logic                 reject_d;
  logic [NUM_ITEMS-1:0] sold_d;

  coin_sel_e            coin;
  logic                 coin_extra;
  logic [SUM_W-1:0]     coin_sum;
  logic                 coin_fits;
  logic                 coin_accept;
  logic                 sel_ok;
  logic                 do_cancel;
  logic                 do_buy;
  logic                 timeout_hit;

  logic                 chg_load;
  logic                 chg_run;
  logic                 chg_done;
  logic [CREDIT_W-1:0]  chg_rem;

  always_comb begin
    coin = COIN_NONE;
    if (Q) begin
      coin = COIN_Q;
    end else if (D) begin
      coin = COIN_D;
    end else if (N) begin
      coin = COIN_N;
    end
    coin_extra = (Q && (D || N)) || (D && N);
    coin_sum   = {1'b0, credit_q} + SUM_W'(coin_value(coin));
    coin_fits  = (coin_sum <= SUM_W'(CREDIT_MAX));

    // Out-of-range sel never matches an index, so it reads as unavailable.
    sel_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if ((sel == SEL_W'(i)) && (stock_q[i] != '0)) begin
        sel_ok = 1'b1;
      end
    end

    do_cancel   = (state_q == CREDIT) && (cancel || timeout_hit);
    do_buy      = (state_q == CREDIT) && !do_cancel && buy && sel_ok &&
                  (credit_q >= CREDIT_W'(PRICE));
    coin_accept = (coin != COIN_NONE) && coin_fits &&
                  ((state_q == IDLE) || ((state_q == CREDIT) && !do_cancel && !do_buy));
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    stock_d     = stock_q;
    vend_d      = 1'b0;
    vend_item_d = vend_item;
    chg_load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (coin_accept) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          state_d  = CREDIT;
        end
      end
      CREDIT: begin
        if (do_cancel) begin
          chg_load = 1'b1;
          credit_d = '0;
          state_d  = CHANGE;
        end else if (do_buy) begin
          state_d     = VEND;
          credit_d    = credit_q - CREDIT_W'(PRICE);
          vend_d      = 1'b1;
          vend_item_d = sel;
          for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            if (sel == SEL_W'(i)) begin
              stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
          end
        end else if (coin_accept) begin
          credit_d = coin_sum[CREDIT_W-1:0];
        end
      end
      VEND: begin
        if (credit_q != '0) begin
          chg_load = 1'b1;
          credit_d = '0;
          state_d  = CHANGE;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        if (chg_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    reject_d = (coin != COIN_NONE) && (!coin_accept || coin_extra);
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      sold_d[i] = (stock_d[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
      vend        <= 1'b0;
      vend_item   <= '0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
      sold_out    <= {NUM_ITEMS{STOCK_INIT == 0}};
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      stock_q     <= stock_d;
      vend        <= vend_d;
      vend_item   <= vend_item_d;
      coin_reject <= reject_d;
      busy        <= (state_d == VEND) || (state_d == CHANGE);
      sold_out    <= sold_d;
    end
  end

`ifdef REFUND_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state_q == CREDIT) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if ((state_q != CREDIT) || (state_d != CREDIT) || coin_accept || buy) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign chg_run = (state_q == CHANGE);
  assign credit  = chg_run ? chg_rem : credit_q;

  vm_change_dispenser #(
    .CREDIT_W(CREDIT_W)
  ) u_change (
    .clk      (clk),
    .reset    (reset),
    .load     (chg_load),
    .load_val (credit_q),
    .run      (chg_run),
    .change_d (change_d),
    .change_n (change_n),
    .remainder(chg_rem),
    .done     (chg_done)
  );

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi: stimulus queues expected responses, a monitor checks them.
module tb_vending_machine_multi;

`ifdef REFUND_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 1000;
`endif

  logic       clk;
  logic       reset;
  logic       N, D, Q, buy, cancel;
  logic [1:0] sel;
  logic       vend;
  logic [1:0] vend_item;
  logic       change_d, change_n, coin_reject, busy;
  logic [6:0] credit;
  logic [3:0] sold_out;

  vending_machine_multi #(
    .PRICE      (15),
    .CREDIT_MAX (95),
    .CREDIT_W   (7),
    .NUM_ITEMS  (4),
    .STOCK_INIT (3),
    .STOCK_W    (4),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .N          (N),
    .D          (D),
    .Q          (Q),
    .buy        (buy),
    .sel        (sel),
    .cancel     (cancel),
    .vend       (vend),
    .vend_item  (vend_item),
    .change_d   (change_d),
    .change_n   (change_n),
    .coin_reject(coin_reject),
    .credit     (credit),
    .sold_out   (sold_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         probe;
    string      tag;
    logic       vend;
    logic [1:0] item;
    logic       cd;
    logic       cn;
    logic       rej;
    logic [6:0] credit;
    logic [3:0] sold;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  bit   stim_done;

  // ---------------- stimulus ----------------
  task automatic step(input logic n, input logic d, input logic q, input logic b,
                      input logic [1:0] s, input logic c);
    N = n; D = d; Q = q; buy = b; sel = s; cancel = c;
    @(posedge clk);
    #1;
    N = 1'b0; D = 1'b0; Q = 1'b0; buy = 1'b0; sel = 2'd0; cancel = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic exp_pulse(input string tag, input logic v, input logic [1:0] it,
                           input logic cd, input logic cn, input logic rj,
                           input logic [6:0] cr, input logic [3:0] so, input logic bz);
    exp_t e;
    e.probe = 1'b0; e.tag = tag; e.vend = v; e.item = it; e.cd = cd; e.cn = cn;
    e.rej = rj; e.credit = cr; e.sold = so; e.busy = bz;
    exp_q.push_back(e);
  endtask

  task automatic exp_probe(input string tag, input logic [6:0] cr, input logic [3:0] so,
                           input logic bz);
    exp_t e;
    e.probe = 1'b1; e.tag = tag; e.vend = 1'b0; e.item = 2'd0; e.cd = 1'b0; e.cn = 1'b0;
    e.rej = 1'b0; e.credit = cr; e.sold = so; e.busy = bz;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; N = 1'b0; D = 1'b0; Q = 1'b0; buy = 1'b0; sel = 2'd0; cancel = 1'b0;
    stim_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Quarter, buy item 2: vend with 10 owed, one dime back
    step(0, 0, 1, 0, 2'd0, 0); exp_probe("q_credit", 7'd25, 4'b0000, 0);
    step(0, 0, 0, 1, 2'd2, 0); exp_pulse("vend_item2", 1, 2'd2, 0, 0, 0, 7'd10, 4'b0000, 1);
    idle();                    exp_pulse("change_dime", 0, 2'd0, 1, 0, 0, 7'd0, 4'b0000, 1);
    idle();                    exp_probe("idle_after_q", 7'd0, 4'b0000, 0);

    // Nickel + dime, exact-price buy of item 0
    step(1, 0, 0, 0, 2'd0, 0); exp_probe("n_credit", 7'd5, 4'b0000, 0);
    step(0, 1, 0, 0, 2'd0, 0); exp_probe("nd_credit", 7'd15, 4'b0000, 0);
    step(0, 0, 0, 1, 2'd0, 0); exp_pulse("vend_item0", 1, 2'd0, 0, 0, 0, 7'd0, 4'b0000, 1);
    idle();                    exp_probe("idle_after_exact", 7'd0, 4'b0000, 0);

    // Credit ceiling: 4th quarter rejected, cancel returns 75 as d x7, n x1
    step(0, 0, 1, 0, 2'd0, 0); exp_probe("q1", 7'd25, 4'b0000, 0);
    step(0, 0, 1, 0, 2'd0, 0); exp_probe("q2", 7'd50, 4'b0000, 0);
    step(0, 0, 1, 0, 2'd0, 0); exp_probe("q3", 7'd75, 4'b0000, 0);
    step(0, 0, 1, 0, 2'd0, 0); exp_pulse("q4_reject", 0, 2'd0, 0, 0, 1, 7'd75, 4'b0000, 0);
    step(0, 0, 0, 0, 2'd0, 1); exp_pulse("refund_d1", 0, 2'd0, 1, 0, 0, 7'd65, 4'b0000, 1);
    for (int k = 0; k < 6; k++) begin
      idle();
      exp_pulse("refund_d", 0, 2'd0, 1, 0, 0, 7'(55 - 10 * k), 4'b0000, 1);
    end
    idle();                    exp_pulse("refund_n", 0, 2'd0, 0, 1, 0, 7'd0, 4'b0000, 1);
    idle();                    exp_probe("idle_after_refund", 7'd0, 4'b0000, 0);

    // Simultaneous Q and D from IDLE: quarter credited, dime rejected
    step(0, 1, 1, 0, 2'd0, 0); exp_pulse("qd_reject", 0, 2'd0, 0, 0, 1, 7'd25, 4'b0000, 0);
    step(0, 0, 0, 0, 2'd0, 1); exp_pulse("qd_cancel_d", 0, 2'd0, 1, 0, 0, 7'd15, 4'b0000, 1);
    idle();                    exp_pulse("qd_cancel_d2", 0, 2'd0, 1, 0, 0, 7'd5, 4'b0000, 1);
    idle();                    exp_pulse("qd_cancel_n", 0, 2'd0, 0, 1, 0, 7'd0, 4'b0000, 1);
    idle();                    exp_probe("idle_after_qd", 7'd0, 4'b0000, 0);

    // Drain item 1; coin during VEND is rejected
    for (int r = 0; r < 3; r++) begin
      step(0, 1, 0, 0, 2'd0, 0);
      step(1, 0, 0, 0, 2'd0, 0);
      step(0, 0, 0, 1, 2'd1, 0);
      exp_pulse("vend_item1", 1, 2'd1, 0, 0, 0, 7'd0, (r == 2) ? 4'b0010 : 4'b0000, 1);
      if (r == 2) begin
        step(1, 0, 0, 0, 2'd0, 0);
        exp_pulse("coin_in_vend", 0, 2'd0, 0, 0, 1, 7'd0, 4'b0010, 0);
      end else begin
        idle();
        exp_probe("idle_after_item1", 7'd0, 4'b0000, 0);
      end
    end
    step(0, 1, 0, 0, 2'd0, 0); exp_probe("d_credit", 7'd10, 4'b0010, 0);
    step(0, 0, 0, 1, 2'd0, 0); exp_probe("buy_short_credit", 7'd10, 4'b0010, 0);
    step(1, 0, 0, 0, 2'd0, 0); exp_probe("dn_credit", 7'd15, 4'b0010, 0);
    step(0, 0, 0, 1, 2'd1, 0); exp_probe("buy_sold_out", 7'd15, 4'b0010, 0);
    step(0, 0, 0, 0, 2'd0, 1); exp_pulse("so_cancel_d", 0, 2'd0, 1, 0, 0, 7'd5, 4'b0010, 1);
    idle();                    exp_pulse("so_cancel_n", 0, 2'd0, 0, 1, 0, 7'd0, 4'b0010, 1);
    idle();                    exp_probe("idle_after_so", 7'd0, 4'b0010, 0);

    // Reset during change with 20 owed: only the first dime appears
    step(0, 0, 1, 0, 2'd0, 0);
    step(0, 1, 0, 0, 2'd0, 0); exp_probe("qd35_credit", 7'd35, 4'b0010, 0);
    step(0, 0, 0, 1, 2'd3, 0); exp_pulse("vend_item3", 1, 2'd3, 0, 0, 0, 7'd20, 4'b0010, 1);
    idle();                    exp_pulse("pre_reset_d", 0, 2'd0, 1, 0, 0, 7'd10, 4'b0010, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle();                    exp_probe("post_reset", 7'd0, 4'b0000, 0);
    step(0, 1, 0, 0, 2'd0, 0);
    step(1, 0, 0, 0, 2'd0, 0);
    step(0, 0, 0, 1, 2'd1, 0); exp_pulse("restocked_vend", 1, 2'd1, 0, 0, 0, 7'd0, 4'b0000, 1);
    idle();                    exp_probe("idle_after_restock", 7'd0, 4'b0000, 0);

`ifdef REFUND_TIMEOUT_EN
    // Idle refund after TIMEOUT_CYC cycles in CREDIT
    step(0, 1, 0, 0, 2'd0, 0); exp_probe("to_credit", 7'd10, 4'b0000, 0);
    for (int k = 0; k < 7; k++) begin
      idle();
      exp_probe("to_waiting", 7'd10, 4'b0000, 0);
    end
    idle();                    exp_pulse("to_refund_d", 0, 2'd0, 1, 0, 0, 7'd0, 4'b0000, 1);
    idle();                    exp_probe("idle_after_to", 7'd0, 4'b0000, 0);
`endif

    idle();
    idle();
    stim_done = 1'b1;
  end

  // ---------------- monitor ----------------
  task automatic check_ev(input exp_t e);
    n_checks++;
    if (vend !== e.vend || (e.vend && vend_item !== e.item) || change_d !== e.cd ||
        change_n !== e.cn || coin_reject !== e.rej || credit !== e.credit ||
        sold_out !== e.sold || busy !== e.busy) begin
      n_fail++;
      $display("FAIL %s: got vend=%0b item=%0d d=%0b n=%0b rej=%0b credit=%0d sold=%b busy=%0b; expected vend=%0b item=%0d d=%0b n=%0b rej=%0b credit=%0d sold=%b busy=%0b",
               e.tag, vend, vend_item, change_d, change_n, coin_reject, credit, sold_out, busy,
               e.vend, e.item, e.cd, e.cn, e.rej, e.credit, e.sold, e.busy);
    end
  endtask

  initial begin
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    while (!stim_done) begin
      @(negedge clk);
      if (!reset) begin
        n_checks++;
        if (vend !== 1'b0 || change_d !== 1'b0 || change_n !== 1'b0 || coin_reject !== 1'b0 ||
            busy !== 1'b0 || credit !== 7'd0 || sold_out !== 4'b0000) begin
          n_fail++;
          $display("FAIL reset_outputs: got vend=%0b d=%0b n=%0b rej=%0b busy=%0b credit=%0d sold=%b; expected all zero",
                   vend, change_d, change_n, coin_reject, busy, credit, sold_out);
        end
      end else if (exp_q.size() > 0 && exp_q[0].probe) begin
        e = exp_q.pop_front();
        check_ev(e);
      end else if (vend || change_d || change_n || coin_reject) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got vend=%0b d=%0b n=%0b rej=%0b credit=%0d; expected no pulse",
                   vend, change_d, change_n, coin_reject, credit);
        end else begin
          e = exp_q.pop_front();
          check_ev(e);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: got %0d unconsumed (first %s); expected 0",
               exp_q.size(), exp_q[0].tag);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
